fan_tacho_monitor: RTL and testbench
====================================

FAN_TACHO_MONITOR -- requirements
Module: fan_tacho_monitor

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter GATE_CYCLES, default 1000000: measurement window length in clk_1m cycles (1 s).
REQ-003 Parameter STALL_MIN, default 4: minimum tacho edges per window for a healthy fan.
REQ-004 Parameter PWM_DIV, default 1: clk_1m cycles per PWM counter step, range 1..255.
REQ-005 clk_1m  in  1  system clock, 1 MHz.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 fan_tacho  in  1  asynchronous open-collector tacho input (fan1_tacho/fan2_tacho).
REQ-008 pwm_duty  in  8  requested duty from the SPI register file, 0x00 = off, 0xFF = full on.
REQ-009 clr_stall  in  1  single-cycle stall-flag clear from the SPI register file.
REQ-010 fan_pwm  out  1  fan PWM drive (fan1_pwm/fan2_pwm).
REQ-011 tacho_count  out  16  rising tacho edges counted in the last completed window.
REQ-012 count_valid  out  1  one-cycle strobe when tacho_count updates.
REQ-013 fan_stall  out  1  sticky stall alarm.

Function
REQ-014 fan_tacho SHALL pass a 2-FF synchronizer, then a glitch filter whose output changes only after 3 consecutive identical synchronized samples.
REQ-015 Each 0->1 transition of the filtered tacho SHALL increment a 16-bit edge counter, which saturates at 0xFFFF.
REQ-016 Gate counter SHALL count 0..GATE_CYCLES-1 and then wrap; the wrap cycle is the terminal cycle.
REQ-017 On the terminal cycle, tacho_count SHALL load the edge count, including any edge in that same cycle, and count_valid SHALL pulse for exactly one cycle.
REQ-018 On the terminal cycle, the edge counter SHALL restart at 0; no edge may be lost or double-counted across the window boundary.
REQ-019 Stall FSM states SHALL be RUN, SUSPECT and STALL, evaluated only on terminal cycles.
- RUN: if count < STALL_MIN, go to SUSPECT; otherwise stay in RUN.
- SUSPECT: if count < STALL_MIN, go to STALL; otherwise return to RUN.
- STALL: stay in STALL until clr_stall has been seen and a window then completes with count >= STALL_MIN; then go to RUN.
REQ-020 fan_stall SHALL be 1 exactly while the FSM is in STALL.
REQ-021 If clr_stall coincides with a terminal cycle that has count >= STALL_MIN, the FSM SHALL leave STALL in that cycle.
REQ-022 If clr_stall arrives in RUN or SUSPECT, it SHALL be ignored.
REQ-023 PWM counter SHALL be 8 bits and advance once per PWM_DIV clk_1m cycles, wrapping 255->0.
REQ-024 pwm_duty SHALL be sampled into a shadow register only when the PWM counter wraps to 0, so duty changes are glitch-free.
REQ-025 fan_pwm SHALL be 1 when the shadow duty is 0xFF; otherwise fan_pwm = (pwm_cnt < shadow duty).
REQ-026 fan_pwm SHALL be registered, with 1-cycle latency from counter state to output.
REQ-027 Measurement and PWM SHALL be independent; PWM duty SHALL NOT affect stall evaluation.

Reset
REQ-028 In reset, the synchronizer, filter, gate, edge and PWM counters SHALL clear to 0.
REQ-029 In reset, tacho_count = 0, count_valid = 0, FSM = RUN, fan_stall = 0.
REQ-030 In reset, the shadow duty SHALL be 0xFF and fan_pwm = 1, so the fan runs at full cooling during reset.
REQ-031 Reset asserted mid-window SHALL discard the partial count; the first valid window starts on the first cycle after reset deasserts.
REQ-032 Reset SHALL take priority over all other inputs in the same cycle.

Verification (GATE_CYCLES=1000, STALL_MIN=4, PWM_DIV=1)
REQ-033 Tacho square wave, 100-cycle period, 50 % duty -> count_valid every 1000 cycles, tacho_count = 10, fan_stall = 0.
REQ-034 1- and 2-cycle tacho glitches only -> tacho_count = 0 after each window; fan_stall rises on the 2nd consecutive terminal cycle.
REQ-035 Stalled fan, then clr_stall with the fan still stopped -> fan_stall stays 1.
REQ-036 Stalled fan, then clr_stall followed by a 10-edge window -> fan_stall falls at that window's terminal cycle.
REQ-037 One 3-edge window followed by a 10-edge window -> FSM returns to RUN, fan_stall never asserts.
REQ-038 pwm_duty = 0x40 -> fan_pwm high 64 of 256 cycles.
REQ-039 pwm_duty changed to 0x80 mid-period -> new duty appears only from the next wrap.
REQ-040 pwm_duty = 0x00 -> fan_pwm constantly 0; pwm_duty = 0xFF -> fan_pwm constantly 1.
REQ-041 rst pulsed at cycle 500 of a window with 5 edges already counted -> the next count_valid comes 1000 cycles after rst deasserts, with only post-reset edges counted.

Source files
------------

// File: rtl/fan_tacho_monitor.sv
// Fan controller: filtered tacho edge counting over a fixed gate window, stall
// detection with a sticky alarm, and an 8-bit PWM drive with shadowed duty.
//
// state     | meaning
// S_RUN     | fan healthy, last window had enough tacho edges
// S_SUSPECT | one window below threshold, waiting for confirmation
// S_STALL   | two consecutive low windows, alarm asserted until cleared
module fan_tacho_monitor #(
  parameter int unsigned GATE_CYCLES = 1000000,
  parameter int unsigned STALL_MIN   = 4,
  parameter int unsigned PWM_DIV     = 1
) (
  input  logic        clk_1m_i,
  input  logic        rst_i,
  input  logic        fan_tacho_i,
  input  logic [7:0]  pwm_duty_i,
  input  logic        clr_stall_i,
  output logic        fan_pwm_o,
  output logic [15:0] tacho_count_o,
  output logic        count_valid_o,
  output logic        fan_stall_o
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [15:0]       STALL_MIN_C = 16'(STALL_MIN);
  localparam logic [7:0]        DIV_LAST    = 8'(PWM_DIV - 1);

  typedef enum logic [1:0] {S_RUN, S_SUSPECT, S_STALL} state_e;

  logic [1:0]        sync_q;
  logic [1:0]        hist_q;
  logic              filt_q, filt_d;
  logic              tacho_rise;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic              terminal;
  logic [15:0]       edge_cnt_q, edge_cnt_d;
  logic [15:0]       win_count;
  logic              window_ok;
  logic [15:0]       tacho_count_q, tacho_count_d;
  logic              count_valid_q;
  state_e            state_q, state_d;
  logic              clr_seen_q, clr_seen_d;
  logic [7:0]        div_q, div_d;
  logic              pwm_step;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;
  logic [7:0]        shadow_q, shadow_d;
  logic              fan_pwm_q, fan_pwm_d;

  // Filter output only moves when the last three synchronized samples agree.
  always_comb begin
    filt_d = filt_q;
    if (sync_q[1] && hist_q[0] && hist_q[1]) begin
      filt_d = 1'b1;
    end else if (!sync_q[1] && !hist_q[0] && !hist_q[1]) begin
      filt_d = 1'b0;
    end
  end

  assign tacho_rise = filt_d & ~filt_q;
  assign terminal   = (gate_q == GATE_LAST);

  // An edge on the terminal cycle still belongs to the window that is closing.
  always_comb begin
    win_count = edge_cnt_q;
    if (tacho_rise && (edge_cnt_q != 16'hFFFF)) begin
      win_count = edge_cnt_q + 16'd1;
    end
    window_ok     = (win_count >= STALL_MIN_C);
    edge_cnt_d    = terminal ? 16'd0 : win_count;
    gate_d        = terminal ? '0 : gate_q + GATE_W'(1);
    tacho_count_d = terminal ? win_count : tacho_count_q;
  end

  always_comb begin
    state_d    = state_q;
    clr_seen_d = clr_seen_q;
    case (state_q)
      S_RUN: begin
        if (terminal && !window_ok) state_d = S_SUSPECT;
      end
      S_SUSPECT: begin
        if (terminal) state_d = window_ok ? S_RUN : S_STALL;
      end
      S_STALL: begin
        if (clr_stall_i) clr_seen_d = 1'b1;
        if (terminal && window_ok && (clr_seen_q || clr_stall_i)) begin
          state_d    = S_RUN;
          clr_seen_d = 1'b0;
        end
      end
      default: begin
        state_d    = S_RUN;
        clr_seen_d = 1'b0;
      end
    endcase
  end

  // Duty is latched only as the counter wraps so a period never mixes duties.
  always_comb begin
    pwm_step  = (div_q == DIV_LAST);
    div_d     = pwm_step ? 8'd0 : div_q + 8'd1;
    pwm_cnt_d = pwm_step ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    shadow_d  = shadow_q;
    if (pwm_step && (pwm_cnt_q == 8'hFF)) shadow_d = pwm_duty_i;
    fan_pwm_d = (shadow_q == 8'hFF) || (pwm_cnt_q < shadow_q);
  end

  always_ff @(posedge clk_1m_i) begin
    if (rst_i) begin
      sync_q        <= 2'b00;
      hist_q        <= 2'b00;
      filt_q        <= 1'b0;
      gate_q        <= '0;
      edge_cnt_q    <= 16'd0;
      tacho_count_q <= 16'd0;
      count_valid_q <= 1'b0;
      state_q       <= S_RUN;
      clr_seen_q    <= 1'b0;
      div_q         <= 8'd0;
      pwm_cnt_q     <= 8'd0;
      shadow_q      <= 8'hFF;
      fan_pwm_q     <= 1'b1;
    end else begin
      sync_q        <= {sync_q[0], fan_tacho_i};
      hist_q        <= {hist_q[0], sync_q[1]};
      filt_q        <= filt_d;
      gate_q        <= gate_d;
      edge_cnt_q    <= edge_cnt_d;
      tacho_count_q <= tacho_count_d;
      count_valid_q <= terminal;
      state_q       <= state_d;
      clr_seen_q    <= clr_seen_d;
      div_q         <= div_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_q      <= shadow_d;
      fan_pwm_q     <= fan_pwm_d;
    end
  end

  assign fan_pwm_o     = fan_pwm_q;
  assign tacho_count_o = tacho_count_q;
  assign count_valid_o = count_valid_q;
  assign fan_stall_o   = (state_q == S_STALL);

endmodule

// File: tb/tb_fan_tacho_monitor.sv
// Directed bench for fan_tacho_monitor with a 1000-cycle gate window: tacho
// patterns are generated relative to each window start, PWM is checked by counting.
module tb_fan_tacho_monitor;

  logic        clk_1m;
  logic        rst;
  logic        fan_tacho;
  logic [7:0]  pwm_duty;
  logic        clr_stall;
  logic        fan_pwm;
  logic [15:0] tacho_count;
  logic        count_valid;
  logic        fan_stall;

  localparam int M_LOW    = 0;
  localparam int M_BURST  = 1;
  localparam int M_GLITCH = 2;

  int n_checks = 0;
  int n_fail   = 0;
  int ph       = 0;
  int mode     = M_LOW;
  int n_pulse  = 0;
  int clr_at   = -1;

  fan_tacho_monitor #(
    .GATE_CYCLES(1000),
    .STALL_MIN  (4),
    .PWM_DIV    (1)
  ) dut (
    .clk_1m_i     (clk_1m),
    .rst_i        (rst),
    .fan_tacho_i  (fan_tacho),
    .pwm_duty_i   (pwm_duty),
    .clr_stall_i  (clr_stall),
    .fan_pwm_o    (fan_pwm),
    .tacho_count_o(tacho_count),
    .count_valid_o(count_valid),
    .fan_stall_o  (fan_stall)
  );

  initial begin
    clk_1m = 1'b0;
    forever #5 clk_1m = ~clk_1m;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Burst: n_pulse pulses of 50 cycles, period 100; glitch: 1- and 2-cycle pulses only.
  function automatic logic tacho_level(input int p);
    int m;
    m = p % 100;
    if (mode == M_BURST) return (p < 100 * n_pulse) && (m >= 10) && (m < 60);
    if (mode == M_GLITCH) return (m == 10) || (m == 50) || (m == 51);
    return 1'b0;
  endfunction

  task automatic tick();
    fan_tacho = tacho_level(ph);
    clr_stall = (ph == clr_at);
    @(posedge clk_1m);
    #1;
    ph++;
  endtask

  task automatic run_window(input int md, input int np, input int clr_ph,
                            input int exp_cnt, input int exp_stall, input string tag);
    int waited;
    bit seen;
    waited = 0;
    seen = 1'b0;
    mode = md;
    n_pulse = np;
    clr_at = clr_ph;
    while (!seen && waited < 1100) begin
      tick();
      waited++;
      if (count_valid) seen = 1'b1;
    end
    chk_val({tag, "_valid"}, 32'(seen), 32'd1);
    chk_val({tag, "_cycles"}, ph, 1000);
    chk_val({tag, "_count"}, 32'(tacho_count), exp_cnt);
    chk_val({tag, "_stall"}, 32'(fan_stall), exp_stall);
    ph = 0;
    clr_at = -1;
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (fan_pwm) highs++;
    end
  endtask

  initial begin
    int highs;
    int w;
    bit found;
    bit prev;
    bit early_valid;

    rst = 1'b1;
    fan_tacho = 1'b0;
    clr_stall = 1'b0;
    pwm_duty = 8'h40;
    repeat (4) tick();
    chk_val("rst_count", 32'(tacho_count), 0);
    chk_val("rst_valid", 32'(count_valid), 0);
    chk_val("rst_stall", 32'(fan_stall), 0);
    chk_val("rst_pwm", 32'(fan_pwm), 1);
    rst = 1'b0;
    ph = 0;

    // healthy fan, 10 edges per window
    run_window(M_BURST, 10, -1, 10, 0, "sq1");
    tick();
    chk_val("valid_width", 32'(count_valid), 0);
    run_window(M_BURST, 10, -1, 10, 0, "sq2");

    // glitches only: stall on second terminal cycle
    run_window(M_GLITCH, 0, -1, 0, 0, "gl1");
    run_window(M_GLITCH, 0, -1, 0, 1, "gl2");

    // good window without clear keeps alarm; clear with stopped fan keeps alarm
    run_window(M_BURST, 10, -1, 10, 1, "noclr");
    run_window(M_LOW, 0, 100, 0, 1, "clr_stopped");
    run_window(M_BURST, 10, 100, 10, 0, "clr_good");

    // clear on the terminal cycle itself releases the alarm
    run_window(M_GLITCH, 0, -1, 0, 0, "gl3");
    run_window(M_GLITCH, 0, -1, 0, 1, "gl4");
    run_window(M_BURST, 10, 999, 10, 0, "clr_term");

    // clear while in RUN is ignored
    run_window(M_LOW, 0, 100, 0, 0, "clr_run");
    run_window(M_LOW, 0, -1, 0, 1, "low2");
    run_window(M_BURST, 10, -1, 10, 1, "run_clr_ign");
    run_window(M_BURST, 10, 100, 10, 0, "clr_good2");

    // single weak window recovers without alarm
    run_window(M_BURST, 3, -1, 3, 0, "weak3");
    run_window(M_BURST, 10, -1, 10, 0, "recover");
    run_window(M_LOW, 0, -1, 0, 0, "after_rec");
    run_window(M_BURST, 10, -1, 10, 0, "pre_rst");

    // reset mid-window after 5 edges
    mode = M_BURST;
    n_pulse = 5;
    early_valid = 1'b0;
    while (ph < 500) begin
      tick();
      if (count_valid) early_valid = 1'b1;
    end
    chk_val("mid_no_valid", 32'(early_valid), 0);
    rst = 1'b1;
    repeat (3) tick();
    chk_val("mid_rst_count", 32'(tacho_count), 0);
    chk_val("mid_rst_pwm", 32'(fan_pwm), 1);
    rst = 1'b0;
    ph = 0;
    run_window(M_BURST, 7, -1, 7, 0, "post_rst");

    // PWM duty levels
    mode = M_LOW;
    pwm_duty = 8'h40;
    repeat (512) tick();
    count_high(256, highs);
    chk_val("pwm_40", highs, 64);
    pwm_duty = 8'h00;
    repeat (512) tick();
    count_high(256, highs);
    chk_val("pwm_00", highs, 0);
    pwm_duty = 8'hFF;
    repeat (512) tick();
    count_high(256, highs);
    chk_val("pwm_ff", highs, 256);
    pwm_duty = 8'hFE;
    repeat (512) tick();
    count_high(256, highs);
    chk_val("pwm_fe", highs, 254);

    // mid-period duty change only takes effect after the wrap
    pwm_duty = 8'h40;
    repeat (512) tick();
    found = 1'b0;
    w = 0;
    prev = fan_pwm;
    while (!found && w < 600) begin
      tick();
      w++;
      if (!prev && fan_pwm) found = 1'b1;
      prev = fan_pwm;
    end
    chk_val("pwm_sync", 32'(found), 1);
    pwm_duty = 8'h80;
    count_high(255, highs);
    chk_val("pwm_old_period", highs, 63);
    count_high(256, highs);
    chk_val("pwm_new_period", highs, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
